plot_framebuffer: RTL and testbench
===================================

// Module: plot_framebuffer
// PURPOSE
//  Sink end of the pixel-plot interface (x, y, colour, plot) driven by the fill/circle datapaths.
//  Stores plotted pixels in an H_RES x V_RES on-chip framebuffer.
//  Streams the stored pixels back out in raster order, paced by a pixel-enable strobe.
//  Provides a hardware clear engine; sits between the drawing datapaths and the video output stage.
// PARAMETERS
//  VGA_X_DW   8    x coordinate width
//  VGA_Y_DW   7    y coordinate width
//  COLOUR_DW  3    bits per pixel
//  H_RES      160  active pixels per line
//  V_RES      120  active lines per frame
//  H_BLANK    40   blank pixel slots per line
//  V_BLANK    10   blank lines per frame
// PORTS
//  clk          in   1          rising-edge clock
//  rst          in   1          synchronous, active-high reset
//  vga_x        in   VGA_X_DW   plot x (unsigned)
//  vga_y        in   VGA_Y_DW   plot y (unsigned)
//  vga_colour   in   COLOUR_DW  plot colour
//  vga_plot     in   1          write request, 1 pixel per cycle
//  plot_ready   out  1          1 = writes accepted (low during clear)
//  clear_start  in   1          start full-screen clear (level, sampled in IDLE)
//  clear_colour in   COLOUR_DW  clear colour, captured on clear_start
//  clear_done   out  1          1-cycle pulse after last clear write
//  pix_en       in   1          scanout advance strobe
//  rd_x         out  VGA_X_DW   x of rd_colour
//  rd_y         out  VGA_Y_DW   y of rd_colour
//  rd_colour    out  COLOUR_DW  pixel data (0 when not rd_valid)
//  rd_valid     out  1          rd_colour is an active-area pixel
//  frame_start  out  1          pulse with pixel (0,0)
//  drop_count   out  16         saturating count of dropped writes
// BEHAVIOUR
//  - Reset: all outputs 0 except plot_ready=1; FSM=IDLE; scan counters=0.
//  - Framebuffer RAM contents are not reset.
//  - Address = y*H_RES + x; one write port, one read port; RAM has a registered read.
//  - Write accepted when vga_plot && plot_ready && x<H_RES && y<V_RES; RAM updated at the next edge.
//  - Write dropped, drop_count+1 (saturating at 16'hFFFF), when:
//    - vga_plot with coordinates off-screen, or
//    - vga_plot while plot_ready=0.
//  - FSM IDLE: clear_start -> CLEAR; capture clear_colour; addr=0; plot_ready<=0.
//  - FSM CLEAR: write clear_colour at addr each cycle, addr+1.
//    - At addr==H_RES*V_RES-1: final write, -> IDLE, clear_done=1 for 1 cycle, plot_ready<=1.
//    - A full clear takes exactly H_RES*V_RES cycles; clear_start is ignored in CLEAR.
//  - Scan counters hc (0..H_RES+H_BLANK-1) and vc (0..V_RES+V_BLANK-1) advance only on pix_en.
//    - hc wraps to 0 and increments vc; vc wraps to 0 after the last line.
//  - Read latency: pix_en at (hc,vc) -> 1 cycle later rd_x/rd_y=(hc,vc), rd_colour=RAM data.
//    - rd_valid=1 iff hc<H_RES && vc<V_RES; frame_start=1 iff hc==0 && vc==0.
//    - rd_valid, frame_start and rd_colour are 0 in cycles with no pix_en the cycle before.
//  - Same-address read/write in one cycle: read returns the old data (read-before-write).
//  - Scanout keeps running during CLEAR; it shows a mix of old and cleared pixels.
//  - rst mid-clear aborts the clear: IDLE, plot_ready=1, no clear_done, RAM partially cleared.
// TESTING
//  - Reset: rst=1 for 2 cycles -> plot_ready=1, rd_valid=0, drop_count=0, clear_done=0.
//  - Clear then scan, clear_colour=3'b101:
//    - clear_done exactly 19200 cycles after start;
//    - full frame of pix_en -> 19200 rd_valid beats, all colour 5.
//  - Plot (159,119,c=2) and (0,0,c=7), pix_en continuous:
//    - frame_start beat shows colour 7;
//    - last active beat shows colour 2 with rd_x=159, rd_y=119.
//  - Plots at (160,0), (0,120), (200,127), plus 2 plots issued during a clear:
//    - drop_count=5, RAM unchanged at row 0/col 0.
//  - Write (5,5)=4 in the same cycle that pix_en reads (5,5) holding 1:
//    - that beat returns 1; next frame returns 4.
//  - Assert rst at clear addr 100:
//    - no clear_done, plot_ready=1 next cycle;
//    - addr 0..99 cleared, addr 100+ old data.

Source files
------------

// File: rtl/plot_framebuffer.sv
// Pixel-plot sink: stores plotted pixels in an on-chip framebuffer, streams them back in raster
// order on a pixel-enable strobe, and provides a hardware full-screen clear engine.
module plot_framebuffer #(
  parameter int VGA_X_DW  = 8,
  parameter int VGA_Y_DW  = 7,
  parameter int COLOUR_DW = 3,
  parameter int H_RES     = 160,
  parameter int V_RES     = 120,
  parameter int H_BLANK   = 40,
  parameter int V_BLANK   = 10
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [VGA_X_DW-1:0]  i_vga_x,
  input  logic [VGA_Y_DW-1:0]  i_vga_y,
  input  logic [COLOUR_DW-1:0] i_vga_colour,
  input  logic                 i_vga_plot,
  output logic                 o_plot_ready,
  input  logic                 i_clear_start,
  input  logic [COLOUR_DW-1:0] i_clear_colour,
  output logic                 o_clear_done,
  input  logic                 i_pix_en,
  output logic [VGA_X_DW-1:0]  o_rd_x,
  output logic [VGA_Y_DW-1:0]  o_rd_y,
  output logic [COLOUR_DW-1:0] o_rd_colour,
  output logic                 o_rd_valid,
  output logic                 o_frame_start,
  output logic [15:0]          o_drop_count
);

  localparam int NPIX   = H_RES * V_RES;
  localparam int AW     = $clog2(NPIX);
  localparam int HTOTAL = H_RES + H_BLANK;
  localparam int VTOTAL = V_RES + V_BLANK;
  localparam int HC_W   = $clog2(HTOTAL);
  localparam int VC_W   = $clog2(VTOTAL);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t               r_state, w_nextState;
  logic [AW-1:0]        r_clrAddr;
  logic [COLOUR_DW-1:0] r_clrColour;
  logic                 r_clearDone;
  logic                 w_plotReady;
  logic                 w_clrLast;

  logic                 w_onScreen, w_plotAccept, w_plotDrop;
  logic [AW-1:0]        w_plotAddr;
  logic                 w_we;
  logic [AW-1:0]        w_wrAddr;
  logic [COLOUR_DW-1:0] w_wrData;

  logic [COLOUR_DW-1:0] r_mem [0:NPIX-1];
  logic [COLOUR_DW-1:0] r_rdData;

  logic [HC_W-1:0]      r_hc;
  logic [VC_W-1:0]      r_vc;
  logic                 w_active, w_rdEn;
  logic [AW-1:0]        w_rdAddr;
  logic [VGA_X_DW-1:0]  r_rdX;
  logic [VGA_Y_DW-1:0]  r_rdY;
  logic                 r_rdValid, r_frameStart;
  logic [15:0]          r_dropCount;

  assign w_clrLast = (r_clrAddr == AW'(NPIX - 1));

  always_comb begin
    w_nextState = r_state;
    w_plotReady = 1'b1;
    case (r_state)
      ST_IDLE:  if (i_clear_start) w_nextState = ST_CLEAR;
      ST_CLEAR: begin
        w_plotReady = 1'b0;
        if (w_clrLast) w_nextState = ST_IDLE;
      end
      default:  w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_clrAddr   <= '0;
      r_clrColour <= '0;
      r_clearDone <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_clearDone <= (r_state == ST_CLEAR) && w_clrLast;
      if (r_state == ST_IDLE && i_clear_start) begin
        r_clrColour <= i_clear_colour;
        r_clrAddr   <= '0;
      end else if (r_state == ST_CLEAR) begin
        r_clrAddr   <= r_clrAddr + 1'b1;
      end
    end
  end

  assign w_onScreen   = (32'(i_vga_x) < H_RES) && (32'(i_vga_y) < V_RES);
  assign w_plotAddr   = AW'(32'(i_vga_y) * H_RES + 32'(i_vga_x));
  assign w_plotAccept = i_vga_plot && w_plotReady && w_onScreen;
  assign w_plotDrop   = i_vga_plot && !(w_plotReady && w_onScreen);

  // The clear engine owns the write port; writes are suppressed while reset is held so an
  // aborted clear leaves the current address untouched.
  always_comb begin
    w_we     = 1'b0;
    w_wrAddr = w_plotAddr;
    w_wrData = i_vga_colour;
    if (r_state == ST_CLEAR) begin
      w_we     = !i_rst;
      w_wrAddr = r_clrAddr;
      w_wrData = r_clrColour;
    end else if (w_plotAccept) begin
      w_we     = !i_rst;
    end
  end

  assign w_active = (32'(r_hc) < H_RES) && (32'(r_vc) < V_RES);
  assign w_rdAddr = AW'(32'(r_vc) * H_RES + 32'(r_hc));
  assign w_rdEn   = i_pix_en && w_active;

  always_ff @(posedge i_clk) begin
    if (w_we) r_mem[w_wrAddr] <= w_wrData;
    if (w_rdEn) r_rdData <= r_mem[w_rdAddr];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hc         <= '0;
      r_vc         <= '0;
      r_rdX        <= '0;
      r_rdY        <= '0;
      r_rdValid    <= 1'b0;
      r_frameStart <= 1'b0;
    end else if (i_pix_en) begin
      r_rdX        <= VGA_X_DW'(r_hc);
      r_rdY        <= VGA_Y_DW'(r_vc);
      r_rdValid    <= w_active;
      r_frameStart <= (r_hc == '0) && (r_vc == '0);
      if (32'(r_hc) == HTOTAL - 1) begin
        r_hc <= '0;
        r_vc <= (32'(r_vc) == VTOTAL - 1) ? '0 : r_vc + 1'b1;
      end else begin
        r_hc <= r_hc + 1'b1;
      end
    end else begin
      r_rdValid    <= 1'b0;
      r_frameStart <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_dropCount <= '0;
    else if (w_plotDrop && r_dropCount != 16'hFFFF) r_dropCount <= r_dropCount + 1'b1;
  end

  assign o_plot_ready  = w_plotReady;
  assign o_clear_done  = r_clearDone;
  assign o_rd_x        = r_rdX;
  assign o_rd_y        = r_rdY;
  assign o_rd_valid    = r_rdValid;
  assign o_rd_colour   = r_rdValid ? r_rdData : '0;
  assign o_frame_start = r_frameStart;
  assign o_drop_count  = r_dropCount;

endmodule

// File: tb/tb_plot_framebuffer.sv
// Directed self-checking bench for plot_framebuffer: clear, scanout, plotting, drops,
// read-before-write collision and reset during a clear.
module tb_plot_framebuffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic        plot_ready;
  logic        clear_start;
  logic [2:0]  clear_colour;
  logic        clear_done;
  logic        pix_en;
  logic [7:0]  rd_x;
  logic [6:0]  rd_y;
  logic [2:0]  rd_colour;
  logic        rd_valid;
  logic        frame_start;
  logic [15:0] drop_count;

  int errors = 0;
  int checks = 0;

  logic [2:0] seen [0:19199];
  int validBeats, frameStarts, lastX, lastY, doneSeen, cycles, badCount;
  logic [2:0] fsColour, lastC;

  plot_framebuffer dut (
    .i_clk(clk), .i_rst(rst),
    .i_vga_x(vga_x), .i_vga_y(vga_y), .i_vga_colour(vga_colour), .i_vga_plot(vga_plot),
    .o_plot_ready(plot_ready),
    .i_clear_start(clear_start), .i_clear_colour(clear_colour), .o_clear_done(clear_done),
    .i_pix_en(pix_en),
    .o_rd_x(rd_x), .o_rd_y(rd_y), .o_rd_colour(rd_colour), .o_rd_valid(rd_valid),
    .o_frame_start(frame_start), .o_drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic plotPixel(input int x, input int y, input int c);
    vga_x = 8'(x); vga_y = 7'(y); vga_colour = 3'(c); vga_plot = 1'b1;
    @(posedge clk); #1;
    vga_plot = 1'b0;
  endtask

  // Runs n pix_en beats from the current scan position; at beat hook the bench also
  // writes colour 4 to (5,5) in the same cycle as that beat's read.
  task automatic scanBeats(input int n, input int hook);
    int a;
    validBeats = 0; frameStarts = 0;
    pix_en = 1'b1;
    for (int k = 0; k < n; k++) begin
      if (k == hook) begin
        vga_x = 8'd5; vga_y = 7'd5; vga_colour = 3'd4; vga_plot = 1'b1;
      end
      @(posedge clk); #1;
      vga_plot = 1'b0;
      if (rd_valid === 1'b1) begin
        validBeats++;
        a = int'(rd_y) * 160 + int'(rd_x);
        if (a < 19200) seen[a] = rd_colour;
        lastX = int'(rd_x); lastY = int'(rd_y); lastC = rd_colour;
      end
      if (frame_start === 1'b1) begin
        frameStarts++;
        fsColour = rd_colour;
      end
    end
    pix_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; vga_x = '0; vga_y = '0; vga_colour = '0; vga_plot = 1'b0;
    clear_start = 1'b0; clear_colour = '0; pix_en = 1'b0;
    for (int i = 0; i < 19200; i++) seen[i] = 3'd0;

    // reset
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checkVal("reset_plot_ready", 32'(plot_ready), 32'd1);
    checkVal("reset_rd_valid", 32'(rd_valid), 32'd0);
    checkVal("reset_drop_count", 32'(drop_count), 32'd0);
    checkVal("reset_clear_done", 32'(clear_done), 32'd0);
    checkVal("reset_frame_start", 32'(frame_start), 32'd0);

    // full clear to colour 5
    clear_colour = 3'b101; clear_start = 1'b1;
    @(posedge clk); #1;
    clear_start = 1'b0;
    checkVal("clear_plot_ready_low", 32'(plot_ready), 32'd0);
    cycles = 0;
    while (clear_done !== 1'b1 && cycles < 20000) begin
      @(posedge clk); #1;
      cycles++;
    end
    checkVal("clear_done_latency", 32'(cycles), 32'd19200);
    checkVal("clear_plot_ready_back", 32'(plot_ready), 32'd1);
    @(posedge clk); #1;
    checkVal("clear_done_one_cycle", 32'(clear_done), 32'd0);

    // full frame scan after clear
    scanBeats(26000, -1);
    checkVal("frame1_valid_beats", 32'(validBeats), 32'd19200);
    checkVal("frame1_frame_starts", 32'(frameStarts), 32'd1);
    badCount = 0;
    for (int i = 0; i < 19200; i++) if (seen[i] !== 3'd5) badCount++;
    checkVal("frame1_all_colour5", 32'(badCount), 32'd0);
    checkVal("idle_rd_colour_zero", 32'(rd_colour), 32'd0);
    checkVal("idle_rd_valid_zero", 32'(rd_valid), 32'd0);

    // plots and off-screen drops
    plotPixel(159, 119, 2);
    plotPixel(0, 0, 7);
    plotPixel(5, 5, 1);
    plotPixel(160, 0, 3);
    plotPixel(0, 120, 3);
    plotPixel(200, 127, 3);
    checkVal("drop_offscreen", 32'(drop_count), 32'd3);

    // frame with read/write collision at (5,5) on beat 5*200+5
    scanBeats(26000, 1005);
    checkVal("frame2_fs_colour", 32'(fsColour), 32'd7);
    checkVal("frame2_last_x", 32'(lastX), 32'd159);
    checkVal("frame2_last_y", 32'(lastY), 32'd119);
    checkVal("frame2_last_colour", 32'(lastC), 32'd2);
    checkVal("frame2_collision_old", 32'(seen[805]), 32'd1);
    checkVal("frame2_offscreen_alias", 32'(seen[160]), 32'd5);
    checkVal("frame2_valid_beats", 32'(validBeats), 32'd19200);

    scanBeats(1006, -1);
    checkVal("frame3_collision_new", 32'(seen[805]), 32'd4);

    // second clear: two plots dropped mid-clear, then reset at clear address 100
    clear_colour = 3'b110; clear_start = 1'b1;
    @(posedge clk); #1;
    clear_start = 1'b0;
    doneSeen = 0;
    for (int j = 1; j <= 100; j++) begin
      @(posedge clk); #1;
      if (clear_done === 1'b1) doneSeen++;
      vga_plot = 1'b0;
      if (j == 49) begin vga_x = 8'd0; vga_y = 7'd0; vga_colour = 3'd1; vga_plot = 1'b1; end
      if (j == 50) begin vga_x = 8'd1; vga_y = 7'd0; vga_colour = 3'd1; vga_plot = 1'b1; end
    end
    vga_plot = 1'b0;
    checkVal("drop_total", 32'(drop_count), 32'd5);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    if (clear_done === 1'b1) doneSeen++;
    checkVal("abort_plot_ready", 32'(plot_ready), 32'd1);
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      if (clear_done === 1'b1) doneSeen++;
    end
    checkVal("abort_no_clear_done", 32'(doneSeen), 32'd0);

    scanBeats(161, -1);
    badCount = 0;
    for (int i = 0; i < 100; i++) if (seen[i] !== 3'd6) badCount++;
    checkVal("abort_cleared_0_99", 32'(badCount), 32'd0);
    checkVal("abort_dropped_00", 32'(seen[0]), 32'd6);
    checkVal("abort_old_100", 32'(seen[100]), 32'd5);
    checkVal("abort_old_159", 32'(seen[159]), 32'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
